// File: rtl/word_pipe_elastic_pkg.sv
// Shared helpers for the elastic word pipeline.
package word_pipe_elastic_pkg;

   // Width needed to count 0..2*depth held words.
   function automatic int occ_width(input int depth);
      return $clog2(2 * depth + 1);
   endfunction

endpackage

// File: rtl/word_skid_stage.sv
// One elastic stage: a main register feeding downstream plus a skid register
// that absorbs the word arriving in the cycle downstream stalls.
module word_skid_stage #(
   parameter int               WIDTH      = 32,
   parameter logic [WIDTH-1:0] RESET_WORD = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             up_valid,
   output logic             up_ready,
   input  logic [WIDTH-1:0] up_word,
   output logic             dn_valid,
   input  logic             dn_ready,
   output logic [WIDTH-1:0] dn_word,
   output logic [1:0]       held
);

   logic             main_v, skid_v;
   logic [WIDTH-1:0] main_d, skid_d;
   logic             accept;

   // Ready comes straight from a register, so no ready path crosses the stage.
   assign up_ready = !skid_v;
   assign accept   = up_valid && up_ready;
   assign dn_valid = main_v;
   assign dn_word  = main_d;
   assign held     = {1'b0, main_v} + {1'b0, skid_v};

   always_ff @(posedge clk) begin
      if (reset) begin
         main_v <= 1'b0;
         skid_v <= 1'b0;
         main_d <= RESET_WORD;
         skid_d <= RESET_WORD;
      end else if (flush) begin
         main_v <= 1'b0;
         skid_v <= 1'b0;
      end else if (dn_ready || !main_v) begin
         if (skid_v) begin
            main_v <= 1'b1;
            main_d <= skid_d;
         end else begin
            main_v <= accept;
            if (accept) main_d <= up_word;
         end
         skid_v <= 1'b0;
      end else if (accept) begin
         skid_v <= 1'b1;
         skid_d <= up_word;
      end
   end

endmodule

// File: rtl/word_pipe_elastic.sv
// Chain of DEPTH skid stages with valid/ready flow control, flush and an
// occupancy count; capacity is 2*DEPTH words.
module word_pipe_elastic
   import word_pipe_elastic_pkg::*;
#(
   parameter int               WIDTH      = 32,
   parameter int               DEPTH      = 1,
   parameter logic [WIDTH-1:0] RESET_WORD = '0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          flush,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [WIDTH-1:0]              in_word,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [WIDTH-1:0]              out_word,
   output logic [occ_width(DEPTH)-1:0]   occupancy
);

   localparam int OCC_W = occ_width(DEPTH);

   // Index i is the link feeding stage i; index DEPTH is the output link.
   logic [DEPTH:0]             vld;
   logic [DEPTH:0]             rdy;
   logic [DEPTH:0][WIDTH-1:0]  wd;
   logic [DEPTH-1:0][1:0]      held;

   assign vld[0]      = in_valid;
   assign wd[0]       = in_word;
   assign rdy[DEPTH]  = out_ready;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      word_skid_stage #(
         .WIDTH      (WIDTH),
         .RESET_WORD (RESET_WORD)
      ) u_stage (
         .clk      (clk),
         .reset    (reset),
         .flush    (flush),
         .up_valid (vld[i]),
         .up_ready (rdy[i]),
         .up_word  (wd[i]),
         .dn_valid (vld[i+1]),
         .dn_ready (rdy[i+1]),
         .dn_word  (wd[i+1]),
         .held     (held[i])
      );
   end

   assign in_ready  = rdy[0] && !flush && !reset;
   assign out_valid = vld[DEPTH];
   assign out_word  = wd[DEPTH];

   always_comb begin
      occupancy = '0;
      for (int i = 0; i < DEPTH; i++) occupancy = occupancy + OCC_W'(held[i]);
   end

endmodule

// File: tb/tb_word_pipe_elastic.sv
// Bench for word_pipe_elastic: four instances (DEPTH 1..4) driven by vector
// tables, directed corner sequences and a randomized scoreboard run.
module tb_word_pipe_elastic;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset, flush;
   logic [3:0]        iv, ordy;
   logic [3:0][31:0]  iw;
   wire  [3:0]        ir, ov;
   wire  [3:0][31:0]  ow;
   wire  [1:0]        occ0;
   wire  [2:0]        occ1, occ2;
   wire  [3:0]        occ3;

   int vectors = 0;
   int miscompares = 0;

   word_pipe_elastic #(.WIDTH(32), .DEPTH(1), .RESET_WORD(32'h0)) u_d1 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(iv[0]), .in_ready(ir[0]), .in_word(iw[0]),
      .out_valid(ov[0]), .out_ready(ordy[0]), .out_word(ow[0]), .occupancy(occ0));
   word_pipe_elastic #(.WIDTH(32), .DEPTH(2), .RESET_WORD(32'h0)) u_d2 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(iv[1]), .in_ready(ir[1]), .in_word(iw[1]),
      .out_valid(ov[1]), .out_ready(ordy[1]), .out_word(ow[1]), .occupancy(occ1));
   word_pipe_elastic #(.WIDTH(32), .DEPTH(3), .RESET_WORD(32'hFFFF_FFFF)) u_d3 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(iv[2]), .in_ready(ir[2]), .in_word(iw[2]),
      .out_valid(ov[2]), .out_ready(ordy[2]), .out_word(ow[2]), .occupancy(occ2));
   word_pipe_elastic #(.WIDTH(32), .DEPTH(4), .RESET_WORD(32'h0)) u_d4 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(iv[3]), .in_ready(ir[3]), .in_word(iw[3]),
      .out_valid(ov[3]), .out_ready(ordy[3]), .out_word(ow[3]), .occupancy(occ3));

   typedef struct {
      int          k;
      logic        v;
      logic [31:0] w;
      logic        r;
      logic        e_ir;
      logic        e_ov;
      logic [31:0] e_ow;
      int          e_occ;
   } vec_t;

   vec_t tbl[$];

   function automatic int occ_of(input int k);
      case (k)
         0:       return int'(occ0);
         1:       return int'(occ1);
         2:       return int'(occ2);
         default: return int'(occ3);
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Inputs change just after the rising edge; outputs are sampled on the falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] mq[$];
      logic [31:0] got_q[$];
      logic [31:0] exp_w;
      int n, sent, emitted, seen;

      reset = 1'b1; flush = 1'b0; iv = '0; ordy = '0; iw = '0;
      repeat (2) tick();
      settle();
      chk("reset_in_ready", 64'(ir), 64'h0);
      chk("reset_out_valid", 64'(ov), 64'h0);
      chk("reset_word_d3", 64'(ow[2]), 64'hFFFF_FFFF);
      chk("reset_word_d1", 64'(ow[0]), 64'h0);
      chk("reset_occ_d4", 64'(occ_of(3)), 64'h0);
      reset = 1'b0;
      tick();
      settle();
      chk("post_reset_in_ready", 64'(ir), 64'hF);
      tick();

      // Streaming through DEPTH=3, then single-stage fill/drain on DEPTH=1.
      tbl.push_back('{2, 1'b1, 32'h1, 1'b1, 1'b1, 1'b0, 32'h0, 0});
      tbl.push_back('{2, 1'b1, 32'h2, 1'b1, 1'b1, 1'b0, 32'h0, 1});
      tbl.push_back('{2, 1'b1, 32'h3, 1'b1, 1'b1, 1'b0, 32'h0, 2});
      tbl.push_back('{2, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h1, 3});
      tbl.push_back('{2, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h2, 2});
      tbl.push_back('{2, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h3, 1});
      tbl.push_back('{2, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 0});
      tbl.push_back('{0, 1'b1, 32'h7, 1'b0, 1'b1, 1'b0, 32'h0, 0});
      tbl.push_back('{0, 1'b1, 32'h8, 1'b0, 1'b1, 1'b1, 32'h7, 1});
      tbl.push_back('{0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h7, 2});
      tbl.push_back('{0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h7, 2});
      tbl.push_back('{0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h8, 1});
      tbl.push_back('{0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 0});

      foreach (tbl[i]) begin
         iv[tbl[i].k] = tbl[i].v;
         iw[tbl[i].k] = tbl[i].w;
         ordy[tbl[i].k] = tbl[i].r;
         settle();
         chk($sformatf("tbl%0d_in_ready", i), 64'(ir[tbl[i].k]), 64'(tbl[i].e_ir));
         chk($sformatf("tbl%0d_out_valid", i), 64'(ov[tbl[i].k]), 64'(tbl[i].e_ov));
         if (tbl[i].e_ov)
            chk($sformatf("tbl%0d_out_word", i), 64'(ow[tbl[i].k]), 64'(tbl[i].e_ow));
         chk($sformatf("tbl%0d_occ", i), 64'(occ_of(tbl[i].k)), 64'(tbl[i].e_occ));
         tick();
      end
      iv = '0; ordy = '0;

      // Fill DEPTH=2 with downstream stalled: only 2*DEPTH words fit.
      n = 0;
      iv[1] = 1'b1;
      for (int c = 0; c < 12; c++) begin
         iw[1] = 32'hA0 + 32'(n);
         settle();
         if (ir[1]) n++;
         tick();
      end
      iv[1] = 1'b0;
      settle();
      chk("full_accepted", 64'(n), 64'd4);
      chk("full_occ", 64'(occ_of(1)), 64'd4);
      chk("full_in_ready", 64'(ir[1]), 64'h0);
      ordy[1] = 1'b1;
      for (int c = 0; c < 16; c++) begin
         if (ov[1]) got_q.push_back(ow[1]);
         if (c == 1) chk("drain_in_ready_1edge", 64'(ir[1]), 64'h0);
         if (c == 2) chk("drain_in_ready_2edges", 64'(ir[1]), 64'h1);
         tick();
         settle();
      end
      chk("drain_count", 64'(got_q.size()), 64'd4);
      foreach (got_q[i]) chk($sformatf("drain_word%0d", i), 64'(got_q[i]), 64'(32'hA0 + 32'(i)));
      chk("drain_occ", 64'(occ_of(1)), 64'h0);
      ordy[1] = 1'b0;
      tick();

      // Random traffic on DEPTH=4 against a plain FIFO model.
      sent = 0; emitted = 0;
      for (int cyc = 0; cyc < 30000 && emitted < 1000; cyc++) begin
         iv[3]   = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
         iw[3]   = $urandom;
         ordy[3] = 1'($urandom_range(0, 1));
         settle();
         chk("rand_occ", 64'(occ_of(3)), 64'(mq.size()));
         if (occ_of(3) > 8) chk("rand_occ_bound", 64'(occ_of(3)), 64'd8);
         if (mq.size() == 8) chk("rand_full_in_ready", 64'(ir[3]), 64'h0);
         if (ov[3] && $isunknown(ow[3])) chk("rand_x_word", 64'(ow[3]), 64'h0);
         if (ir[3] && iv[3]) begin
            mq.push_back(iw[3]);
            sent++;
         end
         if (ov[3] && ordy[3]) begin
            if (mq.size() == 0) begin
               chk("rand_emit_empty", 64'(ow[3]), 64'h0);
               chk("rand_emit_empty_flag", 64'h1, 64'h0 + 64'(mq.size()));
            end else begin
               exp_w = mq.pop_front();
               chk("rand_word", 64'(ow[3]), 64'(exp_w));
            end
            emitted++;
         end
         tick();
      end
      chk("rand_emitted", 64'(emitted), 64'd1000);
      iv[3] = 1'b0; ordy[3] = 1'b0;

      // Flush with a word pending on the input; it must never appear.
      ordy[2] = 1'b0;
      for (int c = 0; c < 3; c++) begin
         iv[2] = 1'b1;
         iw[2] = 32'h11 * 32'(c + 1);
         tick();
      end
      iw[2] = 32'hDEAD;
      flush = 1'b1;
      settle();
      chk("flush_in_ready", 64'(ir[2]), 64'h0);
      chk("flush_pre_occ", 64'(occ_of(2)), 64'd3);
      tick();
      flush = 1'b0; iv[2] = 1'b0;
      settle();
      chk("flush_out_valid", 64'(ov[2]), 64'h0);
      chk("flush_occ", 64'(occ_of(2)), 64'h0);
      chk("flush_in_ready_after", 64'(ir[2]), 64'h1);
      ordy[2] = 1'b1;
      seen = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         settle();
         if (ov[2]) seen++;
      end
      chk("flush_nothing_emitted", 64'(seen), 64'h0);
      tick();

      // Reset mid-stream, then latency of the first word afterwards.
      for (int c = 0; c < 3; c++) begin
         iv[2] = 1'b1;
         iw[2] = 32'h100 + 32'(c);
         tick();
      end
      reset = 1'b1;
      settle();
      chk("midreset_in_ready", 64'(ir[2]), 64'h0);
      tick();
      reset = 1'b0;
      iw[2] = 32'h5;
      settle();
      chk("midreset_out_valid", 64'(ov[2]), 64'h0);
      chk("midreset_out_word", 64'(ow[2]), 64'hFFFF_FFFF);
      chk("midreset_occ", 64'(occ_of(2)), 64'h0);
      chk("midreset_in_ready_after", 64'(ir[2]), 64'h1);
      tick();
      iv[2] = 1'b0;
      settle();
      chk("lat_edge1_valid", 64'(ov[2]), 64'h0);
      tick();
      settle();
      chk("lat_edge2_valid", 64'(ov[2]), 64'h0);
      tick();
      settle();
      chk("lat_edge3_valid", 64'(ov[2]), 64'h1);
      chk("lat_edge3_word", 64'(ow[2]), 64'h5);
      tick();
      ordy = '0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
